wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter and register scoreboard for the RV64IM core. It accepts completed results from three producers: the single-cycle ALU, the load unit and the iterative MUL/DIV unit. It grants at most one result per cycle and drives the register file write port (RD, RD_DATA, WRITE_ENABLE). It also tracks destination registers of in-flight long-latency operations so decode can stall on RAW and WAW hazards.

## Interface
Parameters:
- XLEN, 64, data width of results and write port
- STARVE_LIMIT, 4, consecutive lost-arbitration cycles before a waiting source is promoted (1..15)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- LD_VALID / LD_READY  in / out  1  load result handshake
- LD_RD  in  5  load destination register
- LD_DATA  in  XLEN  load result
- MD_VALID / MD_READY  in / out  1  MUL/DIV result handshake
- MD_RD  in  5  MUL/DIV destination register
- MD_DATA  in  XLEN  MUL/DIV result
- ALU_VALID / ALU_READY  in / out  1  ALU result handshake
- ALU_RD  in  5  ALU destination register
- ALU_DATA  in  XLEN  ALU result
- ISSUE_VALID  in  1  decode issues a load or MUL/DIV op
- ISSUE_RD  in  5  destination of the issued op
- ISSUE_READY  out  1  issue accepted this cycle
- QUERY_R1, QUERY_R2  in  5  source registers under decode
- BUSY_R1, BUSY_R2  out  1  queried register has a pending write
- RD  out  5  register file write index
- RD_DATA  out  XLEN  register file write data
- WRITE_ENABLE  out  1  register file write strobe
- PENDING_COUNT  out  6  number of set scoreboard bits (0..31)

## Operation
- Handshake: a transfer occurs when VALID and READY are both 1 at a rising edge. Sources hold VALID, RD and DATA stable until accepted. READY is combinational from the grant, and at most one READY is high per cycle.
- Base priority: LD > MD > ALU.
- Starvation guard: MD and ALU each have a 4-bit wait counter.
  - The counter increments each cycle its source is VALID and not granted.
  - It clears on grant or when VALID is 0, and saturates at STARVE_LIMIT.
  - A source whose counter equals STARVE_LIMIT is promoted above LD. If both are promoted, MD wins.
- Write port: on accept, register {RD, RD_DATA} and set WRITE_ENABLE=1 for exactly one cycle. Acceptances with RD=0 complete the handshake but drive WRITE_ENABLE=0.
- Scoreboard: 32 pending bits; bit 0 is hardwired to 0.
  - ISSUE_READY = ISSUE_VALID-independent: 1 unless pending[ISSUE_RD] is set. ISSUE_READY is 1 for ISSUE_RD=0.
  - An accepted issue with ISSUE_RD≠0 sets pending[ISSUE_RD].
  - An accepted LD or MD result clears pending[its RD]. ALU results never touch the scoreboard.
  - If a set and a clear of the same bit occur in the same edge, set wins.
- BUSY_Rn = pending[QUERY_Rn], combinational from the register.
- PENDING_COUNT is the registered popcount of the pending bits.
- LD or MD results arriving with pending[RD]=0 are still written. This is not an error.

## Timing
- Reset values: RD=0, RD_DATA=0, WRITE_ENABLE=0, all pending bits 0, PENDING_COUNT=0, wait counters 0.
- While RESET=1, all READY outputs and ISSUE_READY are 0.
- Latency: a result accepted at edge N appears on WRITE_ENABLE/RD/RD_DATA during cycle N..N+1. Its pending bit reads 0 in that same cycle, so decode sees BUSY drop exactly when the register file holds the new value.
- Throughput: one write per cycle, sustained.
- RESET asserted mid-operation discards any in-flight write register and clears all pending bits at that edge. Sources must re-present results after reset.
- Idle (no VALID): WRITE_ENABLE=0. RD and RD_DATA hold their last values.

## Test plan
- Single ALU result: ALU_RD=5, ALU_DATA=0x1234 accepted at edge N → cycle after: WRITE_ENABLE=1, RD=5, RD_DATA=0x1234. The next cycle: WRITE_ENABLE=0.
- Collision: LD (RD=3), MD (RD=4) and ALU (RD=6) all valid → writes occur in order x3, x4, x6 on three consecutive cycles, with each READY high only on its grant cycle.
- Starvation: LD held valid continuously while ALU is valid → ALU is granted on the 5th cycle (STARVE_LIMIT=4). The ALU wait counter returns to 0.
- Scoreboard round-trip: issue ISSUE_RD=7; QUERY_R1=7 → BUSY_R1=1 and PENDING_COUNT=1. A second issue to x7 sees ISSUE_READY=0. After LD returns RD=7 → BUSY_R1=0 in the WRITE_ENABLE cycle and PENDING_COUNT=0.
- Same-edge set/clear: MD result for x9 accepted on the same edge as a new issue to x9 → pending[9] remains 1 and PENDING_COUNT stays 1.
- x0 and reset: ALU result with RD=0 → handshake completes and WRITE_ENABLE stays 0. Issue with ISSUE_RD=0 → PENDING_COUNT stays 0. Asserting RESET with 3 pending bits set → PENDING_COUNT=0 and all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the RV64IM core: picks one of LD/MD/ALU results per
// cycle, drives the register file write port, and keeps a pending-write
// scoreboard for long-latency ops so decode can stall on RAW/WAW hazards.
module wb_arbiter #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            LD_VALID,
    output logic            LD_READY,
    input  logic [4:0]      LD_RD,
    input  logic [XLEN-1:0] LD_DATA,
    input  logic            MD_VALID,
    output logic            MD_READY,
    input  logic [4:0]      MD_RD,
    input  logic [XLEN-1:0] MD_DATA,
    input  logic            ALU_VALID,
    output logic            ALU_READY,
    input  logic [4:0]      ALU_RD,
    input  logic [XLEN-1:0] ALU_DATA,
    input  logic            ISSUE_VALID,
    input  logic [4:0]      ISSUE_RD,
    output logic            ISSUE_READY,
    input  logic [4:0]      QUERY_R1,
    input  logic [4:0]      QUERY_R2,
    output logic            BUSY_R1,
    output logic            BUSY_R2,
    output logic [4:0]      RD,
    output logic [XLEN-1:0] RD_DATA,
    output logic            WRITE_ENABLE,
    output logic [5:0]      PENDING_COUNT
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {SrcNone, SrcLd, SrcMd, SrcAlu} src_e;

    src_e            grant;
    logic            md_promoted, alu_promoted;
    logic            accept, issue_accept;
    logic [4:0]      acc_rd;
    logic [XLEN-1:0] acc_data;
    logic [31:0]     set_mask, clr_mask;

    logic [3:0]      md_wait_q, md_wait_d;
    logic [3:0]      alu_wait_q, alu_wait_d;
    logic [31:0]     pending_q, pending_d;
    logic [5:0]      count_q, count_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic            we_q, we_d;

    // Grant selection: starved sources jump ahead of LD, MD first among them.
    always_comb begin
        grant        = SrcNone;
        md_promoted  = MD_VALID && (md_wait_q == Limit);
        alu_promoted = ALU_VALID && (alu_wait_q == Limit);
        if (!RESET) begin
            if (md_promoted)      grant = SrcMd;
            else if (alu_promoted) grant = SrcAlu;
            else if (LD_VALID)     grant = SrcLd;
            else if (MD_VALID)     grant = SrcMd;
            else if (ALU_VALID)    grant = SrcAlu;
        end
        LD_READY  = (grant == SrcLd);
        MD_READY  = (grant == SrcMd);
        ALU_READY = (grant == SrcAlu);
        accept    = (grant != SrcNone);
    end

    // Result mux and write-port next state.
    always_comb begin
        acc_rd   = '0;
        acc_data = '0;
        unique case (grant)
            SrcLd:  begin acc_rd = LD_RD;  acc_data = LD_DATA;  end
            SrcMd:  begin acc_rd = MD_RD;  acc_data = MD_DATA;  end
            SrcAlu: begin acc_rd = ALU_RD; acc_data = ALU_DATA; end
            default: ;
        endcase
        rd_d      = accept ? acc_rd : rd_q;
        rd_data_d = accept ? acc_data : rd_data_q;
        we_d      = accept && (acc_rd != 5'd0);
    end

    // Wait counters: count lost cycles while valid, saturating at the limit.
    always_comb begin
        md_wait_d  = '0;
        alu_wait_d = '0;
        if (MD_VALID && grant != SrcMd) begin
            md_wait_d = (md_wait_q == Limit) ? Limit : md_wait_q + 4'd1;
        end
        if (ALU_VALID && grant != SrcAlu) begin
            alu_wait_d = (alu_wait_q == Limit) ? Limit : alu_wait_q + 4'd1;
        end
    end

    // Scoreboard next state; a same-edge set overrides a clear.
    always_comb begin
        ISSUE_READY  = !RESET && !pending_q[ISSUE_RD];
        issue_accept = ISSUE_VALID && ISSUE_READY;
        set_mask     = '0;
        clr_mask     = '0;
        if (issue_accept) set_mask[ISSUE_RD] = 1'b1;
        if (grant == SrcLd || grant == SrcMd) clr_mask[acc_rd] = 1'b1;
        pending_d    = ((pending_q & ~clr_mask) | set_mask) & ~32'h1;
        count_d      = '0;
        for (int i = 0; i < 32; i++) begin
            count_d = count_d + 6'(pending_d[i]);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            md_wait_q  <= '0;
            alu_wait_q <= '0;
            pending_q  <= '0;
            count_q    <= '0;
            rd_q       <= '0;
            rd_data_q  <= '0;
            we_q       <= 1'b0;
        end else begin
            md_wait_q  <= md_wait_d;
            alu_wait_q <= alu_wait_d;
            pending_q  <= pending_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            rd_data_q  <= rd_data_d;
            we_q       <= we_d;
        end
    end

    assign BUSY_R1       = pending_q[QUERY_R1];
    assign BUSY_R2       = pending_q[QUERY_R2];
    assign RD            = rd_q;
    assign RD_DATA       = rd_data_q;
    assign WRITE_ENABLE  = we_q;
    assign PENDING_COUNT = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model of the writeback rules.
module tb_wb_arbiter;

    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        LD_VALID = 0, MD_VALID = 0, ALU_VALID = 0, ISSUE_VALID = 0;
    logic        LD_READY, MD_READY, ALU_READY, ISSUE_READY;
    logic [4:0]  LD_RD = 0, MD_RD = 0, ALU_RD = 0, ISSUE_RD = 0;
    logic [63:0] LD_DATA = 0, MD_DATA = 0, ALU_DATA = 0;
    logic [4:0]  QUERY_R1 = 0, QUERY_R2 = 0;
    logic        BUSY_R1, BUSY_R2, WRITE_ENABLE;
    logic [4:0]  RD;
    logic [63:0] RD_DATA;
    logic [5:0]  PENDING_COUNT;

    wb_arbiter #(.XLEN(64), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RESET(RESET),
        .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_RD(LD_RD), .LD_DATA(LD_DATA),
        .MD_VALID(MD_VALID), .MD_READY(MD_READY), .MD_RD(MD_RD), .MD_DATA(MD_DATA),
        .ALU_VALID(ALU_VALID), .ALU_READY(ALU_READY), .ALU_RD(ALU_RD),
        .ALU_DATA(ALU_DATA),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD), .ISSUE_READY(ISSUE_READY),
        .QUERY_R1(QUERY_R1), .QUERY_R2(QUERY_R2), .BUSY_R1(BUSY_R1), .BUSY_R2(BUSY_R2),
        .RD(RD), .RD_DATA(RD_DATA), .WRITE_ENABLE(WRITE_ENABLE),
        .PENDING_COUNT(PENDING_COUNT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    // Reference model state: registered outputs, scoreboard, starvation counts.
    bit          m_pend[32];
    int          m_mdw = 0, m_aluw = 0;
    logic        m_we = 0;
    logic [4:0]  m_rd = 0;
    logic [63:0] m_data = 0;
    int          last_win = 0;  // 0 none, 1 LD, 2 MD, 3 ALU
    logic        obs_alu_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_winner();
        if (RESET) return 0;
        if (MD_VALID && m_mdw == LIMIT) return 2;
        if (ALU_VALID && m_aluw == LIMIT) return 3;
        if (LD_VALID) return 1;
        if (MD_VALID) return 2;
        if (ALU_VALID) return 3;
        return 0;
    endfunction

    function automatic int popcount();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    // Compare this cycle's DUT outputs with the model, then advance the model.
    task automatic tick();
        int w;
        logic ir;
        logic [4:0] wrd;
        logic [63:0] wdat;
        @(negedge CLK);
        w  = pick_winner();
        ir = !RESET && !m_pend[ISSUE_RD];
        obs_alu_rdy = ALU_READY;
        chk("ld_ready", 64'(LD_READY), 64'(w == 1));
        chk("md_ready", 64'(MD_READY), 64'(w == 2));
        chk("alu_ready", 64'(ALU_READY), 64'(w == 3));
        chk("issue_ready", 64'(ISSUE_READY), 64'(ir));
        chk("busy_r1", 64'(BUSY_R1), 64'(m_pend[QUERY_R1]));
        chk("busy_r2", 64'(BUSY_R2), 64'(m_pend[QUERY_R2]));
        chk("write_enable", 64'(WRITE_ENABLE), 64'(m_we));
        chk("rd", 64'(RD), 64'(m_rd));
        chk("rd_data", RD_DATA, m_data);
        chk("pending_count", 64'(PENDING_COUNT), 64'(popcount()));
        last_win = w;
        if (RESET) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_mdw = 0; m_aluw = 0; m_we = 0; m_rd = 0; m_data = 0;
        end else begin
            wrd = (w == 1) ? LD_RD : (w == 2) ? MD_RD : ALU_RD;
            wdat = (w == 1) ? LD_DATA : (w == 2) ? MD_DATA : ALU_DATA;
            if (w != 0) begin
                m_rd = wrd; m_data = wdat;
            end
            m_we = (w != 0) && (wrd != 0);
            if (w == 1 || w == 2) m_pend[wrd] = 0;
            if (ISSUE_VALID && ir && ISSUE_RD != 0) m_pend[ISSUE_RD] = 1;
            m_mdw = (!MD_VALID || w == 2) ? 0 : ((m_mdw + 1 > LIMIT) ? LIMIT : m_mdw + 1);
            m_aluw = (!ALU_VALID || w == 3) ? 0 : ((m_aluw + 1 > LIMIT) ? LIMIT : m_aluw + 1);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drop_accepted();
        if (last_win == 1) LD_VALID = 0;
        if (last_win == 2) MD_VALID = 0;
        if (last_win == 3) ALU_VALID = 0;
    endtask

    logic [4:0] coll_exp[3];
    int alu_at;

    initial begin
        foreach (m_pend[i]) m_pend[i] = 0;
        @(posedge CLK);
        #1;
        tick();                       // reset values
        RESET = 0;
        tick();

        // Single ALU result.
        ALU_VALID = 1; ALU_RD = 5; ALU_DATA = 64'h1234;
        tick();
        drop_accepted();
        chk("alu_single_we", 64'(WRITE_ENABLE), 64'd1);
        chk("alu_single_rd", 64'(RD), 64'd5);
        chk("alu_single_data", RD_DATA, 64'h1234);
        tick();
        chk("alu_single_idle", 64'(WRITE_ENABLE), 64'd0);

        // Three-way collision drains LD, MD, ALU in order.
        coll_exp[0] = 5'd3; coll_exp[1] = 5'd4; coll_exp[2] = 5'd6;
        LD_VALID = 1; LD_RD = 3; LD_DATA = 64'hAAA3;
        MD_VALID = 1; MD_RD = 4; MD_DATA = 64'hBBB4;
        ALU_VALID = 1; ALU_RD = 6; ALU_DATA = 64'hCCC6;
        for (int k = 0; k < 3; k++) begin
            tick();
            drop_accepted();
            chk("collision_rd", 64'(RD), 64'(coll_exp[k]));
        end
        tick();

        // Starvation: LD always valid, ALU wins on its 5th waiting cycle, twice.
        for (int rep = 0; rep < 2; rep++) begin
            LD_VALID = 1; ALU_VALID = 1; ALU_RD = 5'(20 + rep);
            alu_at = 0;
            for (int k = 1; k <= 5; k++) begin
                LD_RD = 5'(10 + k); LD_DATA = 64'(k);
                tick();
                if (obs_alu_rdy && alu_at == 0) alu_at = k;
            end
            chk("starve_grant_cycle", 64'(alu_at), 64'd5);
            ALU_VALID = 0;
        end
        LD_VALID = 0;
        tick();

        // Scoreboard round trip on x7.
        ISSUE_VALID = 1; ISSUE_RD = 7; QUERY_R1 = 7;
        tick();
        ISSUE_VALID = 0;
        chk("sb_busy", 64'(BUSY_R1), 64'd1);
        chk("sb_count", 64'(PENDING_COUNT), 64'd1);
        ISSUE_VALID = 1;
        #1;
        chk("sb_reissue_blocked", 64'(ISSUE_READY), 64'd0);
        LD_VALID = 1; LD_RD = 7; LD_DATA = 64'h77;
        tick();
        LD_VALID = 0; ISSUE_VALID = 0;
        chk("sb_ret_we", 64'(WRITE_ENABLE), 64'd1);
        chk("sb_ret_busy", 64'(BUSY_R1), 64'd0);
        chk("sb_ret_count", 64'(PENDING_COUNT), 64'd0);
        tick();

        // Same-edge set and clear on x9: the set survives.
        MD_VALID = 1; MD_RD = 9; MD_DATA = 64'h99;
        ISSUE_VALID = 1; ISSUE_RD = 9; QUERY_R2 = 9;
        tick();
        MD_VALID = 0; ISSUE_VALID = 0;
        chk("same_edge_busy", 64'(BUSY_R2), 64'd1);
        chk("same_edge_count", 64'(PENDING_COUNT), 64'd1);
        LD_VALID = 1; LD_RD = 9;
        tick();
        LD_VALID = 0;

        // x0 results and issues.
        ALU_VALID = 1; ALU_RD = 0; ALU_DATA = 64'h5;
        #1;
        chk("x0_ready", 64'(ALU_READY), 64'd1);
        tick();
        ALU_VALID = 0;
        chk("x0_no_write", 64'(WRITE_ENABLE), 64'd0);
        ISSUE_VALID = 1; ISSUE_RD = 0;
        tick();
        ISSUE_VALID = 0;
        chk("x0_issue_count", 64'(PENDING_COUNT), 64'd0);

        // Reset with three pending bits and a recent write.
        for (int k = 1; k <= 3; k++) begin
            ISSUE_VALID = 1; ISSUE_RD = 5'(k);
            ALU_VALID = 1; ALU_RD = 12; ALU_DATA = 64'(k);
            tick();
        end
        ISSUE_VALID = 0; ALU_VALID = 0;
        chk("pre_reset_count", 64'(PENDING_COUNT), 64'd3);
        RESET = 1;
        tick();
        RESET = 0;
        chk("reset_count", 64'(PENDING_COUNT), 64'd0);
        chk("reset_we", 64'(WRITE_ENABLE), 64'd0);
        chk("reset_rd", 64'(RD), 64'd0);
        chk("reset_data", RD_DATA, 64'd0);
        tick();

        // Random traffic; sources hold their result until accepted.
        for (int c = 0; c < 400; c++) begin
            if (!LD_VALID || last_win == 1) begin
                LD_VALID = 1'($urandom_range(0, 1));
                LD_RD = 5'($urandom_range(0, 15)); LD_DATA = {$urandom, $urandom};
            end
            if (!MD_VALID || last_win == 2) begin
                MD_VALID = 1'($urandom_range(0, 1));
                MD_RD = 5'($urandom_range(0, 15)); MD_DATA = {$urandom, $urandom};
            end
            if (!ALU_VALID || last_win == 3) begin
                ALU_VALID = 1'($urandom_range(0, 1));
                ALU_RD = 5'($urandom_range(0, 31)); ALU_DATA = {$urandom, $urandom};
            end
            ISSUE_VALID = 1'($urandom_range(0, 1));
            ISSUE_RD = 5'($urandom_range(0, 15));
            QUERY_R1 = 5'($urandom_range(0, 15));
            QUERY_R2 = 5'($urandom_range(0, 15));
            RESET = ($urandom_range(0, 59) == 0);
            tick();
        end
        RESET = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
